pio_gen2: RTL



---
 rtl/pio_gen2_pkg.sv | 26 ++
 rtl/pio_gen2_if.sv | 29 ++
 rtl/pio_sync_edge.sv | 57 +++++
 rtl/pio_gen2.sv | 115 +++++++++++
 4 files changed

// File: rtl/pio_gen2_pkg.sv
// ============================================================================
// Module      : pio_gen2_pkg
// Description : Shared register offsets and mode encodings for pio_gen2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pio_gen2_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

`default_nettype wire

// File: rtl/pio_gen2_if.sv
// ============================================================================
// Module      : pio_gen2_if
// Description : Avalon-MM slave bus bundle for pio_gen2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pio_gen2_if #(
    parameter int DATA_WIDTH = 32
);
    logic [2:0]            address;
    logic                  chipselect;
    logic                  read_n;
    logic                  write_n;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata
    );
endinterface

`default_nettype wire

// File: rtl/pio_sync_edge.sv
// ============================================================================
// Module      : pio_sync_edge
// Description : Input synchroniser chain, previous-value flop and edge select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_sync_edge
    import pio_gen2_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic [DATA_WIDTH-1:0] in_port,
    output logic      [DATA_WIDTH-1:0] sync_in,
    output logic      [DATA_WIDTH-1:0] edge_pulse
);

    logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] r_prev;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("pio_sync_edge: SYNC_STAGES must be 2..4");
    end

    // Whole chain is cleared so no pre-reset sample can turn into an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign sync_in = r_sync[SYNC_STAGES-1];

    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
        assign edge_pulse = sync_in & ~r_prev;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
        assign edge_pulse = ~sync_in & r_prev;
    end else begin : g_any
        assign edge_pulse = sync_in ^ r_prev;
    end

endmodule

`default_nettype wire

// File: rtl/pio_gen2.sv
// ============================================================================
// Module      : pio_gen2
// Description : Avalon-MM GPIO slave with set/clear, edge capture and IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_gen2
    import pio_gen2_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter int          IRQ_TYPE    = IRQ_EDGE,
    parameter int          SYNC_STAGES = 2
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    pio_gen2_if.slave                  bus,
    input  wire logic [DATA_WIDTH-1:0] in_port,
    output logic      [DATA_WIDTH-1:0] out_port,
    output logic      [DATA_WIDTH-1:0] oe,
    output logic                       irq
);

    if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
        $error("pio_gen2: DATA_WIDTH must be 1..32");
    end

    localparam logic [DATA_WIDTH-1:0] c_RESET_VALUE = RESET_VALUE[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] r_dir;
    logic [DATA_WIDTH-1:0] r_irqmask;
    logic [DATA_WIDTH-1:0] r_edge;
    logic [DATA_WIDTH-1:0] r_readdata;
    logic                  r_irq;

    logic                  w_wr;
    logic                  w_rd;
    logic [DATA_WIDTH-1:0] w_sync_in;
    logic [DATA_WIDTH-1:0] w_edge_pulse;
    logic [DATA_WIDTH-1:0] w_edge_clr;
    logic [DATA_WIDTH-1:0] w_rd_mux;
    logic                  w_irq_next;

    pio_sync_edge #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_port),
        .sync_in    (w_sync_in),
        .edge_pulse (w_edge_pulse)
    );

    assign w_wr       = bus.chipselect & ~bus.write_n;
    assign w_rd       = bus.chipselect & ~bus.read_n;
    assign w_edge_clr = (w_wr && bus.address == ADDR_EDGE) ? bus.writedata : '0;

    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    w_rd_mux = (w_sync_in & ~r_dir) | (r_data_out & r_dir);
            ADDR_DIR:     w_rd_mux = r_dir;
            ADDR_IRQMASK: w_rd_mux = r_irqmask;
            ADDR_EDGE:    w_rd_mux = r_edge;
            default:      w_rd_mux = '0;
        endcase
    end

    if (IRQ_TYPE == IRQ_LEVEL) begin : g_irq_level
        assign w_irq_next = |(w_sync_in & r_irqmask);
    end else begin : g_irq_edge
        assign w_irq_next = |(r_edge & r_irqmask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= c_RESET_VALUE;
            r_dir      <= '0;
            r_irqmask  <= '0;
            r_edge     <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr) begin
                case (bus.address)
                    ADDR_DATA:    r_data_out <= bus.writedata;
                    ADDR_DIR:     r_dir      <= bus.writedata;
                    ADDR_IRQMASK: r_irqmask  <= bus.writedata;
                    ADDR_OUTSET:  r_data_out <= r_data_out | bus.writedata;
                    ADDR_OUTCLR:  r_data_out <= r_data_out & ~bus.writedata;
                    default:      ;
                endcase
            end
            // A new edge takes priority over a same-cycle write-1-to-clear.
            r_edge <= (r_edge & ~w_edge_clr) | w_edge_pulse;
            if (w_rd) begin
                r_readdata <= w_rd_mux;
            end
            r_irq <= w_irq_next;
        end
    end

    assign bus.readdata = r_readdata;
    assign out_port     = r_data_out;
    assign oe           = r_dir;
    assign irq          = r_irq;

endmodule

`default_nettype wire
